// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: assembles RV32I instruction words from a one-hot type
// select plus operand fields and buffers them in a DEPTH-entry output FIFO.
// Latency: a word accepted at edge N is visible at the FIFO head after edge N.
// Backpressure: in_ready = !full (no bypass when full); out_instr is held
// while out_valid & !out_ready.
// Ports: clk/rst_n (async active-low); in_valid/in_ready + sel, rd, rs1, rs2,
// funct3, funct7, imm on the request side; out_valid/out_ready + out_instr on
// the delivery side; instr_count counts output transfers (wraps); err pulses
// on a rejected select.
// Optional feature macro: ONEHOT_CHECK_EN. When defined, a select that is not
// exactly one-hot is consumed, not enqueued, and pulses err for one cycle.
// When undefined, the lowest set select bit wins, sel = 0 encodes
// addi x0,x0,0, and err is tied low.
module rv32i_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       sel,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] instr_count,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_SB    = 7'b1100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic [31:0] enc;
  logic        sel_ok;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [31:0] mem [DEPTH];

  // Priority chain: the lowest set select bit decides the format. With no
  // bit set the word falls back to the canonical NOP.
  always_comb begin
    enc = 32'h0000_0013;
    if (sel[0])      enc = {funct7, rs2, rs1, funct3, rd, OP_R};
    else if (sel[1]) enc = {imm[11:0], rs1, funct3, rd, OP_I};
    else if (sel[2]) enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
    else if (sel[3]) enc = {imm[11:0], rs1, funct3, rd, OP_LOAD};
    else if (sel[4]) enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_SB};
    else if (sel[5]) enc = {imm[31:12], rd, OP_AUIPC};
    else if (sel[6]) enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    else if (sel[7]) enc = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
    else if (sel[8]) enc = {imm[31:12], rd, OP_LUI};
  end

`ifdef ONEHOT_CHECK_EN
  // x & (x-1) clears the lowest set bit; zero result with x != 0 means one-hot.
  assign sel_ok = (sel != 9'd0) && ((sel & (sel - 9'd1)) == 9'd0);
`else
  assign sel_ok = 1'b1;
`endif

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign accept    = in_valid & in_ready;
  assign push      = accept & sel_ok;
  assign pop       = out_valid & out_ready;

  // Storage is not reset; the head is forced to zero whenever the FIFO is
  // empty so stale contents never appear on out_instr.
  assign out_instr = empty ? 32'h0000_0000 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= enc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      instr_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_ONE;
        instr_count <= instr_count + CNT_ONE;
      end
    end
  end

`ifdef ONEHOT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= accept & !sel_ok;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Testbench for rv32i_instr_encoder: directed vectors, backpressure, mid-run
// reset, select-validity handling and randomized traffic. Expected words come
// from a field-placement reference model and flow through a scoreboard queue
// that an independent monitor drains as the DUT delivers words.
module tb_rv32i_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  sel = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [15:0] instr_count;
  logic        err;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] sbq[$];
  logic [15:0] cnt_exp = '0;
  bit          rand_rdy = 0;

  rv32i_instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .instr_count(instr_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Extract imm[hi:lo] as a right-aligned number.
  function automatic logic [31:0] fld(input logic [31:0] x, input int hi, input int lo);
    return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference: pick the format from the lowest set select bit, then place
  // each field at its bit offset by shifting.
  function automatic logic [31:0] ref_enc(input logic [8:0] s, input logic [4:0] d,
      input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
    int k = -1;
    logic [31:0] R = 32'(d) << 7, A = 32'(a) << 15, B = 32'(b) << 20, F = 32'(f3) << 12;
    for (int i = 8; i >= 0; i--) if (s[i]) k = i;
    case (k)
      0: return (32'(f7) << 25) + B + A + F + R + 32'h33;
      1: return (fld(im, 11, 0) << 20) + A + F + R + 32'h13;
      2: return (fld(im, 11, 5) << 25) + B + A + F + (fld(im, 4, 0) << 7) + 32'h23;
      3: return (fld(im, 11, 0) << 20) + A + F + R + 32'h03;
      4: return (fld(im, 12, 12) << 31) + (fld(im, 10, 5) << 25) + B + A + F
                + (fld(im, 4, 1) << 8) + (fld(im, 11, 11) << 7) + 32'h63;
      5: return (im & 32'hFFFF_F000) + R + 32'h17;
      6: return (fld(im, 20, 20) << 31) + (fld(im, 10, 1) << 21) + (fld(im, 11, 11) << 20)
                + (fld(im, 19, 12) << 12) + R + 32'h6F;
      7: return (fld(im, 11, 0) << 20) + A + R + 32'h67;
      8: return (im & 32'hFFFF_F000) + R + 32'h37;
      default: return 32'h0000_0013;
    endcase
  endfunction

  // Issue one request and wait (bounded) for it to be accepted. The expected
  // word is queued at the negedge preceding the transfer edge.
  task automatic send(input logic [8:0] s, input logic [4:0] d, input logic [4:0] a,
      input logic [4:0] b, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] im, input logic [31:0] exp_word);
    bit bad = ($countones(s) != 1);
    bit do_push, err_exp, accepted = 0;
`ifdef ONEHOT_CHECK_EN
    do_push = !bad; err_exp = bad;
`else
    do_push = 1; err_exp = 0;
`endif
    sel = s; rd = d; rs1 = a; rs2 = b; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        if (do_push) sbq.push_back(exp_word);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 60 cycles");
    end else begin
      chk("err_after_transfer", {31'b0, err}, {31'b0, err_exp});
    end
  endtask

  task automatic drain();
    bit done = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      done = (sbq.size() == 0) && !out_valid;
    end
    chk("drain_complete", {31'b0, done}, 32'd1);
  endtask

  // Monitor: head must match the scoreboard while valid (also proves the word
  // is held during a stall); a transfer pops and advances the count.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sbq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got %h with empty scoreboard", out_instr);
      end else begin
        chk("out_instr", out_instr, sbq[0]);
        if (out_ready) begin
          chk("instr_count", {16'b0, instr_count}, {16'b0, cnt_exp});
          void'(sbq.pop_front());
          cnt_exp = cnt_exp + 16'd1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_out_instr"}, out_instr, 32'h0);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_instr_count"}, {16'b0, instr_count}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  initial begin
    logic [8:0] s;
    logic [4:0] d, a, b;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] im;

    #3;
    check_reset_state("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed encodings with the consumer always ready.
    out_ready = 1'b1;
    send(9'h001, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3);
    send(9'h002, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093);
    send(9'h004, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423);
    send(9'h010, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE208EE3);
    send(9'h040, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF);
    send(9'h100, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7);
    drain();

    // Reset with three words buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(9'h002, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), ref_enc(9'h002, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i)));
    chk("buffered_before_reset", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    sbq.delete();
    cnt_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Backpressure: four words fill the FIFO, the fifth waits.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(9'h020, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i) << 12, ref_enc(9'h020, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i) << 12));
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    fork
      send(9'h008, 5'd9, 5'd4, 5'd0, 3'd2, 7'd0, 32'h10, ref_enc(9'h008, 5'd9, 5'd4, 5'd0, 3'd2, 7'd0, 32'h10));
      begin
        repeat (2) begin
          @(negedge clk);
          chk("held_off_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("count_after_five", {16'b0, instr_count}, 32'd5);

    // Non-one-hot and empty selects.
    send(9'b000000011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3);
    send(9'b000000000, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h00000013);
    drain();

    // Randomized traffic with a randomly stalling consumer.
    rand_rdy = 1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) s = 9'($urandom_range(0, 511));
      else s = 9'd1 << $urandom_range(0, 8);
      d = 5'($urandom); a = 5'($urandom); b = 5'($urandom);
      f3 = 3'($urandom); f7 = 7'($urandom); im = $urandom;
      send(s, d, a, b, f3, f7, im, ref_enc(s, d, a, b, f3, f7, im));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_rdy = 0;
    #2;
    drain();
    chk("final_count", {16'b0, instr_count}, {16'b0, cnt_exp});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
